// File: rtl/md_pkg.sv
// Shared encodings and op-class helpers for the iterative multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8,
        MD_MTHI  = 4'd9,
        MD_MTLO  = 4'd10
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Any op that occupies the multiplier path, including accumulate forms.
    function automatic logic is_mul(input logic [3:0] op);
        return (op == MD_MULT)  || (op == MD_MULTU) ||
               (op == MD_MADD)  || (op == MD_MADDU) ||
               (op == MD_MSUB)  || (op == MD_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) ||
               (op == MD_MADD) || (op == MD_MSUB);
    endfunction

    // Accumulate into {HI,LO}: add for madd family, subtract for msub family.
    function automatic logic is_madd(input logic [3:0] op);
        return (op == MD_MADD) || (op == MD_MADDU);
    endfunction

    function automatic logic is_msub(input logic [3:0] op);
        return (op == MD_MSUB) || (op == MD_MSUBU);
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// Radix-2 restoring unsigned divider: one quotient bit per step, WIDTH steps.
module md_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   trial;

    // Shift the next dividend bit into the partial remainder and keep the
    // subtraction only when it does not go negative. A zero divisor always
    // "fits", leaving an all-ones quotient and the dividend as remainder.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (clear) begin
            rem_d = '0;
            quo_d = '0;
            dvs_d = '0;
        end else if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit_iter.sv
// Execute-stage multiply/divide unit with multi-cycle multiply, iterative
// divide, multiply-accumulate, mthi/mtlo and a flush that aborts in-flight work.
module md_unit_iter
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Req,
    input  logic             Start,
    input  logic [3:0]       MDUOp,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > WIDTH) ? MULT_CYCLES : WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               div0_q, div0_d;

    logic                      sa, sb, launch;
    logic signed [2*WIDTH-1:0] op_a, op_b, prod;
    logic        [2*WIDTH-1:0] hilo;
    logic                      div_load, div_step, div_clear;
    logic [WIDTH-1:0]          div_quo, div_rem;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Magnitude of a two's-complement value; MIN maps to itself, which the
    // unsigned divider reads correctly as 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? neg_w(x) : x;
    endfunction

    md_div_iter #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .reset     (reset),
        .clear     (div_clear),
        .load      (div_load),
        .step      (div_step),
        .dividend  (abs_w(D1, sa)),
        .divisor   (abs_w(D2, sb)),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Operand signs, full-width product and launch qualification.
    always_comb begin
        sa     = is_signed(MDUOp) & D1[WIDTH-1];
        sb     = is_signed(MDUOp) & D2[WIDTH-1];
        op_a   = $signed({{WIDTH{sa}}, D1});
        op_b   = $signed({{WIDTH{sb}}, D2});
        prod   = op_a * op_b;
        hilo   = {hi_q, lo_q};
        launch = Start && !Req && (state_q == ST_IDLE) &&
                 (is_mul(MDUOp) || is_div(MDUOp));
    end

    // Next-state logic: flush beats completion, completion and mthi/mtlo are
    // mutually exclusive because the latter are only honoured in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div0_d    = div0_q;
        div_load  = 1'b0;
        div_step  = 1'b0;
        div_clear = 1'b0;
        if (Req) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            cnt_d     = '0;
            div_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        busy_d = 1'b1;
                        if (is_mul(MDUOp)) begin
                            state_d = ST_MUL;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            if (is_madd(MDUOp))
                                acc_d = hilo + prod;
                            else if (is_msub(MDUOp))
                                acc_d = hilo - prod;
                            else
                                acc_d = prod;
                        end else begin
                            state_d  = ST_DIV;
                            cnt_d    = CNT_W'(WIDTH);
                            div_load = 1'b1;
                            qneg_d   = sa ^ sb;
                            rneg_d   = sa;
                            div0_d   = (D2 == '0);
                        end
                    end else if (MDUOp == MD_MTHI) begin
                        hi_d = D1;
                    end else if (MDUOp == MD_MTLO) begin
                        lo_d = D1;
                    end
                end
                ST_MUL: begin
                    if (cnt_q == CNT_W'(1)) begin
                        hi_d    = acc_q[2*WIDTH-1:WIDTH];
                        lo_d    = acc_q[WIDTH-1:0];
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    div_step = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = ST_FIX;
                end
                ST_FIX: begin
                    hi_d    = rneg_q ? neg_w(div_rem) : div_rem;
                    lo_d    = div0_q ? '1 : (qneg_q ? neg_w(div_quo) : div_quo);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // FSM, HI/LO and operation context registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
